// File: rtl/jt89_wr_seq_pkg.sv
// Shared types and byte-prefix constants for the jt89 write sequencer.
package jt89_wr_seq_pkg;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HI_W   = 6;

    localparam logic       LATCH     = 1'b1;
    localparam logic       TYPE_TONE = 1'b0;
    localparam logic       TYPE_VOL  = 1'b1;
    localparam logic [1:0] NOISE_CH  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic              vol;
        logic [1:0]        ch;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // First byte of every command: latch + channel + type + low data bits.
    function automatic logic [BYTE_W-1:0] latch_byte(input cmd_t c);
        logic [BYTE_W-1:0] b;
        if (c.vol) begin
            b = {LATCH, c.ch, TYPE_VOL, c.data[3:0]};
        end else if (c.ch == NOISE_CH) begin
            b = {LATCH, NOISE_CH, TYPE_TONE, 1'b0, c.data[2:0]};
        end else begin
            b = {LATCH, c.ch, TYPE_TONE, c.data[3:0]};
        end
        return b;
    endfunction

endpackage

// File: rtl/jt89_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy, full and empty flags.
module jt89_cmd_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push & ~full_q;
        do_pop   = pop & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/jt89_wr_seq.sv
// Queues PSG register commands and plays them onto the jt89 din/wr_n bus
// as latch/data byte sequences with programmable strobe timing.
module jt89_wr_seq
    import jt89_wr_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WR_LOW     = 2,
    parameter int unsigned WR_GAP     = 2,
    parameter int unsigned SKIP_HI    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_vol,
    input  logic [1:0]        cmd_ch,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [BYTE_W-1:0] psg_din,
    output logic              psg_wr_n,
    output logic              busy
);

    localparam int unsigned FCW     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_MAX = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    cmd_t             fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop, push;
    logic [FCW-1:0]   fifo_count;

    wr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] din_q, din_d;
    logic             wr_n_q, wr_n_d;
    logic             busy_q, busy_d;
    logic [HI_W-1:0]  b2_q, b2_d;
    logic             b2_pend_q, b2_pend_d;
    logic [1:0]       b2_ch_q, b2_ch_d;
    logic [HI_W-1:0]  shadow_q [3];
    logic [HI_W-1:0]  shadow_d [3];
    logic             load_next, is_tone;

    assign fifo_wdata = '{vol: cmd_vol, ch: cmd_ch, data: cmd_data};
    assign push       = cmd_valid & ~fifo_full;

    jt89_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Byte sequencer: load, strobe, gap; data byte follows its latch byte directly.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        b2_d      = b2_q;
        b2_pend_d = b2_pend_q;
        b2_ch_d   = b2_ch_q;
        shadow_d  = shadow_q;
        fifo_pop  = 1'b0;
        load_next = 1'b0;
        is_tone   = ~fifo_rdata.vol & (fifo_rdata.ch != NOISE_CH);

        case (state_q)
            IDLE: begin
                load_next = ~fifo_empty;
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(WR_LOW - 1);
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(WR_GAP - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (b2_pend_q) begin
                    state_d           = SETUP;
                    din_d             = {2'b00, b2_q};
                    b2_pend_d         = 1'b0;
                    shadow_d[b2_ch_q] = b2_q;
                end else if (!fifo_empty) begin
                    load_next = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // Skip decision uses the shadow as of pop time; earlier data bytes are already out.
        if (load_next) begin
            fifo_pop  = 1'b1;
            state_d   = SETUP;
            din_d     = latch_byte(fifo_rdata);
            b2_d      = fifo_rdata.data[9:4];
            b2_ch_d   = fifo_rdata.ch;
            b2_pend_d = is_tone &
                        ~((SKIP_HI != 0) && (fifo_rdata.data[9:4] == shadow_q[fifo_rdata.ch]));
        end

        wr_n_d = (state_d != STROBE);
        busy_d = (state_d != IDLE) | push | (fifo_count > FCW'(fifo_pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            din_q     <= '0;
            wr_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            b2_q      <= '0;
            b2_pend_q <= 1'b0;
            b2_ch_q   <= '0;
            shadow_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            wr_n_q    <= wr_n_d;
            busy_q    <= busy_d;
            b2_q      <= b2_d;
            b2_pend_q <= b2_pend_d;
            b2_ch_q   <= b2_ch_d;
            shadow_q  <= shadow_d;
        end
    end

    assign cmd_ready = ~fifo_full;
    assign psg_din   = din_q;
    assign psg_wr_n  = wr_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_jt89_wr_seq.sv
// Scoreboard bench: two sequencer instances (default timing with high-byte skip,
// and 1/1 timing without skip) checked byte-by-byte at each wr_n falling edge.
module tb_jt89_wr_seq;

    localparam int NI = 2;
    localparam int unsigned LOW_P  [NI] = '{2, 1};
    localparam int unsigned GAP_P  [NI] = '{2, 1};
    localparam int unsigned SKIP_P [NI] = '{1, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid [NI];
    logic       cmd_ready [NI];
    logic       cmd_vol   [NI];
    logic [1:0] cmd_ch    [NI];
    logic [9:0] cmd_data  [NI];
    logic [7:0] psg_din   [NI];
    logic       psg_wr_n  [NI];
    logic       busy      [NI];

    logic [7:0] exp_q [NI][$];
    logic       stream_chk [NI];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        jt89_wr_seq #(
            .FIFO_DEPTH (4),
            .WR_LOW     (LOW_P[g]),
            .WR_GAP     (GAP_P[g]),
            .SKIP_HI    (SKIP_P[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_vol   (cmd_vol[g]),
            .cmd_ch    (cmd_ch[g]),
            .cmd_data  (cmd_data[g]),
            .psg_din   (psg_din[g]),
            .psg_wr_n  (psg_wr_n[g]),
            .busy      (busy[g])
        );

        // Monitor: pop expected byte on each strobe, check width, stability and stream pitch
        logic       prev_wr_n   = 1'b1;
        logic       prev_stream = 1'b0;
        logic [7:0] cur         = 8'h00;
        int         low_cnt     = 0;
        int         since_fall  = 0;

        always @(negedge clk) begin
            if (rst) begin
                prev_wr_n   = 1'b1;
                prev_stream = 1'b0;
                low_cnt     = 0;
                since_fall  = 0;
            end else begin
                since_fall++;
                if (prev_wr_n && !psg_wr_n[g]) begin
                    checks++;
                    if (exp_q[g].size() == 0) begin
                        errors++;
                        cur = psg_din[g];
                        $display("FAIL dut%0d byte: got %02h, no byte expected", g, psg_din[g]);
                    end else begin
                        cur = exp_q[g].pop_front();
                        if (psg_din[g] !== cur) begin
                            errors++;
                            $display("FAIL dut%0d byte: got %02h, expected %02h", g, psg_din[g], cur);
                        end
                    end
                    if (stream_chk[g] && prev_stream) begin
                        checks++;
                        if (since_fall != int'(1 + LOW_P[g] + GAP_P[g])) begin
                            errors++;
                            $display("FAIL dut%0d pitch: got %0d cycles/byte, expected %0d",
                                     g, since_fall, 1 + LOW_P[g] + GAP_P[g]);
                        end
                    end
                    prev_stream = stream_chk[g];
                    since_fall  = 0;
                    low_cnt     = 1;
                end else if (!psg_wr_n[g]) begin
                    low_cnt++;
                    checks++;
                    if (psg_din[g] !== cur) begin
                        errors++;
                        $display("FAIL dut%0d din_stable: got %02h, expected %02h", g, psg_din[g], cur);
                    end
                end else if (!prev_wr_n) begin
                    checks++;
                    if (low_cnt != int'(LOW_P[g])) begin
                        errors++;
                        $display("FAIL dut%0d wr_low: got %0d cycles, expected %0d", g, low_cnt, LOW_P[g]);
                    end
                end
                prev_wr_n = psg_wr_n[g];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Offer one command; expected bytes are hand-computed by the caller.
    task automatic send(input int g, input logic vol, input logic [1:0] ch, input logic [9:0] data,
                        input int nb, input logic [7:0] e1, input logic [7:0] e2);
        int t = 0;
        cmd_vol[g]   = vol;
        cmd_ch[g]    = ch;
        cmd_data[g]  = data;
        cmd_valid[g] = 1'b1;
        while (!cmd_ready[g] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready[g]) begin
            chk("accept_timeout", 32'(cmd_ready[g]), 32'd1);
            cmd_valid[g] = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q[g].push_back(e1);
        if (nb == 2) exp_q[g].push_back(e2);
        @(negedge clk);
        cmd_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while ((busy[g] || exp_q[g].size() != 0 || !psg_wr_n[g]) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 32'(busy[g]), 32'd0);
    endtask

    logic [9:0] s_data [8] = '{10'h3FF, 10'h155, 10'h2AA, 10'h001, 10'h3F0, 10'h00F, 10'h120, 10'h0C7};
    logic [7:0] s_b1   [8] = '{8'h8F, 8'hA5, 8'hCA, 8'h81, 8'hA0, 8'hCF, 8'h80, 8'hA7};
    logic [7:0] s_b2   [8] = '{8'h3F, 8'h15, 8'h2A, 8'h00, 8'h3F, 8'h00, 8'h12, 8'h0C};

    logic       f_vol  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] f_ch   [6] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [9:0] f_data [6] = '{10'h3C1, 10'h001, 10'h002, 10'h003, 10'h004, 10'h003};
    int         f_nb   [6] = '{2, 1, 1, 1, 1, 1};
    logic [7:0] f_b1   [6] = '{8'hC1, 8'h91, 8'hB2, 8'hD3, 8'hF4, 8'hE3};

    initial begin
        int t;
        for (int i = 0; i < NI; i++) begin
            cmd_valid[i]  = 1'b0;
            cmd_vol[i]    = 1'b0;
            cmd_ch[i]     = 2'd0;
            cmd_data[i]   = 10'd0;
            stream_chk[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_wr_n",  32'(psg_wr_n[i]),  32'd1);
            chk("reset_din",   32'(psg_din[i]),   32'd0);
            chk("reset_ready", 32'(cmd_ready[i]), 32'd1);
            chk("reset_busy",  32'(busy[i]),      32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Tone ch1 with latency probe: SETUP after E1, wr_n low after E2
        send(0, 1'b0, 2'd1, 10'h2A5, 2, 8'hA5, 8'h2A);
        @(negedge clk);
        chk("lat_setup_wr_n", 32'(psg_wr_n[0]), 32'd1);
        chk("lat_setup_din",  32'(psg_din[0]),  32'hA5);
        chk("lat_busy",       32'(busy[0]),     32'd1);
        @(negedge clk);
        chk("lat_strobe_wr_n", 32'(psg_wr_n[0]), 32'd0);
        wait_idle(0);
        chk("idle_holds_din", 32'(psg_din[0]), 32'h2A);

        // Same high bits: skipped with SKIP_HI, repeated without
        send(0, 1'b0, 2'd1, 10'h2A3, 1, 8'hA3, 8'h00);
        wait_idle(0);
        send(1, 1'b0, 2'd1, 10'h2A5, 2, 8'hA5, 8'h2A);
        send(1, 1'b0, 2'd1, 10'h2A3, 2, 8'hA3, 8'h2A);
        wait_idle(1);

        // Attenuation, repeated noise control, attenuation ignoring data[9:4]
        send(0, 1'b1, 2'd2, 10'h007, 1, 8'hD7, 8'h00);
        send(0, 1'b0, 2'd3, 10'h005, 1, 8'hE5, 8'h00);
        send(0, 1'b0, 2'd3, 10'h005, 1, 8'hE5, 8'h00);
        send(0, 1'b1, 2'd0, 10'h3F2, 1, 8'h92, 8'h00);
        wait_idle(0);

        // Fill the FIFO while the first command is still on the bus
        for (int i = 0; i < 6; i++) begin
            send(0, f_vol[i], f_ch[i], f_data[i], f_nb[i], f_b1[i], 8'h3C);
            if (i == 3) chk("fifo_ready_3", 32'(cmd_ready[0]), 32'd1);
            if (i == 4) chk("fifo_full_ready", 32'(cmd_ready[0]), 32'd0);
        end
        wait_idle(0);

        // Back-to-back stream at 1/1 timing, no skip
        stream_chk[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(1, 1'b0, 2'(i % 3), s_data[i], 2, s_b1[i], s_b2[i]);
        end
        wait_idle(1);
        stream_chk[1] = 1'b0;

        // Reset during the first strobe, then a zero tone needs only its latch byte
        send(0, 1'b0, 2'd0, 10'h3A5, 2, 8'h85, 8'h3A);
        t = 0;
        while (psg_wr_n[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("strobe_seen", 32'(psg_wr_n[0]), 32'd0);
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(negedge clk);
        chk("midrst_wr_n",  32'(psg_wr_n[0]),  32'd1);
        chk("midrst_din",   32'(psg_din[0]),   32'd0);
        chk("midrst_busy",  32'(busy[0]),      32'd0);
        chk("midrst_ready", 32'(cmd_ready[0]), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        send(0, 1'b0, 2'd0, 10'h000, 1, 8'h80, 8'h00);
        wait_idle(0);
        repeat (10) @(negedge clk);

        for (int i = 0; i < NI; i++) begin
            chk("leftover_bytes", 32'(exp_q[i].size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
